// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller: register map, priority type, size limits.
package irq_pkg;

    localparam int NUM_SRC_MAX = 16;

    localparam logic [3:0] IRQ_ENABLE     = 4'h0;
    localparam logic [3:0] IRQ_PENDING    = 4'h1;
    localparam logic [3:0] IRQ_MODE       = 4'h2;
    localparam logic [3:0] IRQ_PRIO       = 4'h3;
    localparam logic [3:0] IRQ_IN_SERVICE = 4'h4;
    localparam logic [3:0] IRQ_EOI        = 4'h5;
    localparam logic [3:0] IRQ_CLAIM      = 4'h6;
    localparam logic [3:0] IRQ_SWTRIG     = 4'h7;

    typedef logic [1:0] irq_prio_t;

endpackage

// File: rtl/irq_prio_arbiter.sv
// Picks the eligible source with the highest 2-bit priority, lowest index on ties.
// Purely combinational, no handshake; winner id is 0 when nothing is eligible.
module irq_prio_arbiter
    import irq_pkg::*;
#(
    parameter int NUM_SRC = 16,
    parameter int ID_W    = 4
) (
    input  logic [NUM_SRC-1:0]   eligible,
    input  logic [2*NUM_SRC-1:0] prio,
    output logic                 win_vld,
    output logic [ID_W-1:0]      win_id,
    output irq_prio_t            win_prio
);

    localparam int LEAVES = NUM_SRC_MAX;
    localparam int LEVELS = $clog2(LEAVES);

    logic            node_vld  [LEVELS+1][LEAVES];
    irq_prio_t       node_prio [LEVELS+1][LEAVES];
    logic [ID_W-1:0] node_id   [LEVELS+1][LEAVES];

    always_comb begin
        for (int l = 0; l <= LEVELS; l++) begin
            for (int n = 0; n < LEAVES; n++) begin
                node_vld[l][n]  = 1'b0;
                node_prio[l][n] = '0;
                node_id[l][n]   = '0;
            end
        end
        for (int n = 0; n < NUM_SRC; n++) begin
            node_vld[0][n]  = eligible[n];
            node_prio[0][n] = prio[2*n +: 2];
            node_id[0][n]   = ID_W'(n);
        end
        // The right (higher index) child only wins on a strictly greater priority.
        for (int l = 0; l < LEVELS; l++) begin
            for (int n = 0; n < (LEAVES >> (l + 1)); n++) begin
                if (node_vld[l][2*n+1] &&
                    (!node_vld[l][2*n] || node_prio[l][2*n+1] > node_prio[l][2*n])) begin
                    node_vld[l+1][n]  = 1'b1;
                    node_prio[l+1][n] = node_prio[l][2*n+1];
                    node_id[l+1][n]   = node_id[l][2*n+1];
                end else begin
                    node_vld[l+1][n]  = node_vld[l][2*n];
                    node_prio[l+1][n] = node_prio[l][2*n];
                    node_id[l+1][n]   = node_id[l][2*n];
                end
            end
        end
    end

    assign win_vld  = node_vld[LEVELS][0];
    assign win_id   = node_id[LEVELS][0];
    assign win_prio = node_prio[LEVELS][0];

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller: pending latch, mask, priority arbitration, claim/EOI nesting.
// irq_req/irq_id registered one cycle after pending; no backpressure, ack is a one-cycle claim.
module irq_controller
    import irq_pkg::*;
#(
    parameter int NUM_SRC = 16,
    parameter int ID_W    = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               reg_en,
    input  logic               reg_we,
    input  logic [3:0]         reg_addr,
    input  logic [31:0]        reg_wdata,
    output logic [31:0]        reg_rdata,
    input  logic [NUM_SRC-1:0] irq_src,
    output logic               irq_req,
    output logic [ID_W-1:0]    irq_id,
    input  logic               irq_ack
);

    localparam int PW = 2 * NUM_SRC;

    logic [NUM_SRC-1:0] src_d1;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] enable;
    logic [NUM_SRC-1:0] mode;
    logic [NUM_SRC-1:0] in_service;
    logic [PW-1:0]      prio;

    logic               wr_vld;
    logic               rd_vld;
    logic [NUM_SRC-1:0] wdat_src;
    logic [NUM_SRC-1:0] ack_hit;
    logic [NUM_SRC-1:0] eoi_hit;
    logic [NUM_SRC-1:0] w1c;
    logic [NUM_SRC-1:0] sw_set;
    logic [NUM_SRC-1:0] mode_chg;
    logic [NUM_SRC-1:0] edge_path;
    logic [NUM_SRC-1:0] edge_set;
    logic [NUM_SRC-1:0] pending_nxt;
    logic [NUM_SRC-1:0] in_service_nxt;
    logic [NUM_SRC-1:0] eligible;
    logic [NUM_SRC-1:0] busy;

    logic               win_vld;
    logic [ID_W-1:0]    win_id;
    irq_prio_t          win_prio;
    irq_prio_t          run_prio;
    logic               run_vld;
    logic               req_nxt;
    logic [31:0]        rd_dat;

    assign wr_vld   = reg_en & reg_we;
    assign rd_vld   = reg_en & ~reg_we;
    assign wdat_src = reg_wdata[NUM_SRC-1:0];

    always_comb begin
        ack_hit = '0;
        eoi_hit = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            ack_hit[i] = irq_ack & irq_req & (irq_id == ID_W'(i));
            eoi_hit[i] = wr_vld & (reg_addr == IRQ_EOI) & (reg_wdata[ID_W-1:0] == ID_W'(i));
        end
    end

    assign w1c      = (wr_vld && reg_addr == IRQ_PENDING) ? wdat_src : '0;
    assign sw_set   = (wr_vld && reg_addr == IRQ_SWTRIG)  ? wdat_src : '0;
    assign mode_chg = (wr_vld && reg_addr == IRQ_MODE)    ? (wdat_src ^ mode) : '0;

    // A bit whose mode flips this cycle goes through the edge path so the flip clears it.
    assign edge_path   = mode | mode_chg;
    assign edge_set    = mode & ((irq_src & ~src_d1) | sw_set);
    assign pending_nxt = (edge_path & ((pending & ~(w1c | ack_hit | mode_chg)) | edge_set))
                       | (~edge_path & irq_src);

    assign in_service_nxt = (in_service & ~eoi_hit) | ack_hit;

    // The source being claimed this cycle already counts as in service for the next decision.
    assign eligible = pending & enable & ~in_service & ~ack_hit;
    assign busy     = in_service | ack_hit;

    irq_prio_arbiter #(
        .NUM_SRC (NUM_SRC),
        .ID_W    (ID_W)
    ) u_arb (
        .eligible (eligible),
        .prio     (prio),
        .win_vld  (win_vld),
        .win_id   (win_id),
        .win_prio (win_prio)
    );

    always_comb begin
        run_prio = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (busy[i] && prio[2*i +: 2] > run_prio) begin
                run_prio = prio[2*i +: 2];
            end
        end
    end

    assign run_vld = |busy;
    assign req_nxt = win_vld & (~run_vld | (win_prio > run_prio));

    always_comb begin
        rd_dat = '0;
        case (reg_addr)
            IRQ_ENABLE:     rd_dat[NUM_SRC-1:0] = enable;
            IRQ_PENDING:    rd_dat[NUM_SRC-1:0] = pending;
            IRQ_MODE:       rd_dat[NUM_SRC-1:0] = mode;
            IRQ_PRIO:       rd_dat[PW-1:0]      = prio;
            IRQ_IN_SERVICE: rd_dat[NUM_SRC-1:0] = in_service;
            IRQ_CLAIM:      rd_dat[ID_W:0]      = {irq_req, irq_id};
            default:        rd_dat = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            src_d1     <= '0;
            pending    <= '0;
            enable     <= '0;
            mode       <= '0;
            in_service <= '0;
            prio       <= '0;
            irq_req    <= 1'b0;
            irq_id     <= '0;
            reg_rdata  <= '0;
        end else begin
            src_d1     <= irq_src;
            pending    <= pending_nxt;
            in_service <= in_service_nxt;
            irq_req    <= req_nxt;
            irq_id     <= win_id;
            if (wr_vld) begin
                case (reg_addr)
                    IRQ_ENABLE: enable <= wdat_src;
                    IRQ_MODE:   mode   <= wdat_src;
                    IRQ_PRIO:   prio   <= reg_wdata[PW-1:0];
                    default:    ;
                endcase
            end
            if (rd_vld) begin
                reg_rdata <= rd_dat;
            end
        end
    end

endmodule
